// File: rtl/oxi_pkg.sv
// Shared pulse-oximeter definitions: LED phase states and front-end code widths.
package oxi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RED  = 2'd1,
    ST_IR   = 2'd2
  } oxi_state_e;

  localparam int unsigned PGA_W = 4;
  localparam int unsigned DC_W  = 8;

endpackage

// File: rtl/adc_window_avg.sv
// Accumulates ADC samples inside the settled window of an LED phase and
// presents the truncated average.
module adc_window_avg #(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned ADC_W    = 8,
  parameter int unsigned TIMER_W  = 4
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               clear,
  input  logic [TIMER_W-1:0] timer,
  input  logic [ADC_W-1:0]   adc,
  output logic [ADC_W-1:0]   avg_c
);

  localparam int unsigned ACC_W    = ADC_W + AVG_LOG2;
  localparam int unsigned WIN_LAST = SETTLE + (1 << AVG_LOG2) - 1;

  logic [ACC_W-1:0] acc_q;
  logic             in_window_c;

  assign in_window_c = (timer >= TIMER_W'(SETTLE)) && (timer <= TIMER_W'(WIN_LAST));

  always_ff @(posedge CLK) begin
    if (rst || clear) begin
      acc_q <= '0;
    end else if (in_window_c) begin
      acc_q <= acc_q + ACC_W'(adc);
    end
  end

  assign avg_c = ADC_W'(acc_q >> AVG_LOG2);

endmodule

// File: rtl/led_adc_sequencer.sv
// Alternates RED/IR LED phases, presents per-phase PGA/DC codes and emits one
// averaged ADC sample with a valid strobe per phase.
module led_adc_sequencer
  import oxi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 10,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned ADC_W       = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             Find_setting_Complete,
  input  logic [ADC_W-1:0] ADC,
  input  logic [PGA_W-1:0] RED_PGA,
  input  logic [PGA_W-1:0] IR_PGA,
  input  logic [DC_W-1:0]  RED_DC_Comp,
  input  logic [DC_W-1:0]  IR_DC_Comp,
  output logic             LED_RED,
  output logic             LED_IR,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic [ADC_W-1:0] IR_ADC_Value,
  output logic             red_valid,
  output logic             ir_valid
);

  localparam int unsigned TIMER_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  oxi_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               phase_end_c;
  logic               acc_clear_c;
  logic [ADC_W-1:0]   avg_c;

  logic               led_red_d, led_ir_d;
  logic [PGA_W-1:0]   pga_d;
  logic [DC_W-1:0]    dc_d;
  logic [ADC_W-1:0]   red_val_d, ir_val_d;
  logic               red_vld_d, ir_vld_d;

  assign phase_end_c = (state_q != ST_IDLE) && (timer_q == TIMER_W'(HALF_PERIOD - 1));
  assign acc_clear_c = (state_q == ST_IDLE) || phase_end_c;

  adc_window_avg #(
    .SETTLE   (SETTLE),
    .AVG_LOG2 (AVG_LOG2),
    .ADC_W    (ADC_W),
    .TIMER_W  (TIMER_W)
  ) u_avg (
    .CLK   (CLK),
    .rst   (rst),
    .clear (acc_clear_c),
    .timer (timer_q),
    .adc   (ADC),
    .avg_c (avg_c)
  );

  // Next state, phase timer and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    pga_d     = PGA_Gain;
    dc_d      = DC_Comp;
    red_val_d = RED_ADC_Value;
    ir_val_d  = IR_ADC_Value;
    red_vld_d = 1'b0;
    ir_vld_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Find_setting_Complete) state_d = ST_RED;
      end
      ST_RED: begin
        if (phase_end_c) begin
          state_d   = Find_setting_Complete ? ST_IR : ST_IDLE;
          red_val_d = avg_c;
          red_vld_d = 1'b1;
        end
      end
      ST_IR: begin
        if (phase_end_c) begin
          state_d  = Find_setting_Complete ? ST_RED : ST_IDLE;
          ir_val_d = avg_c;
          ir_vld_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && !phase_end_c) timer_d = timer_q + 1'b1;

    led_red_d = (state_d == ST_RED);
    led_ir_d  = (state_d == ST_IR);

    // Gain/DC codes are latched only on entry, so they stay fixed for the phase.
    if (state_d != state_q) begin
      case (state_d)
        ST_RED: begin
          pga_d = RED_PGA;
          dc_d  = RED_DC_Comp;
        end
        ST_IR: begin
          pga_d = IR_PGA;
          dc_d  = IR_DC_Comp;
        end
        default: begin
          pga_d = '0;
          dc_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      LED_RED       <= 1'b0;
      LED_IR        <= 1'b0;
      PGA_Gain      <= '0;
      DC_Comp       <= '0;
      RED_ADC_Value <= '0;
      IR_ADC_Value  <= '0;
      red_valid     <= 1'b0;
      ir_valid      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      LED_RED       <= led_red_d;
      LED_IR        <= led_ir_d;
      PGA_Gain      <= pga_d;
      DC_Comp       <= dc_d;
      RED_ADC_Value <= red_val_d;
      IR_ADC_Value  <= ir_val_d;
      red_valid     <= red_vld_d;
      ir_valid      <= ir_vld_d;
    end
  end

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Directed and scoreboard checks for led_adc_sequencer at default parameters.
module tb_led_adc_sequencer;

  logic       CLK;
  logic       rst;
  logic       Find_setting_Complete;
  logic [7:0] ADC;
  logic [3:0] RED_PGA, IR_PGA;
  logic [7:0] RED_DC_Comp, IR_DC_Comp;
  logic       LED_RED, LED_IR;
  logic [3:0] PGA_Gain;
  logic [7:0] DC_Comp;
  logic [7:0] RED_ADC_Value, IR_ADC_Value;
  logic       red_valid, ir_valid;

  int n_checks = 0;
  int n_fail   = 0;

  led_adc_sequencer dut (
    .CLK                   (CLK),
    .rst                   (rst),
    .Find_setting_Complete (Find_setting_Complete),
    .ADC                   (ADC),
    .RED_PGA               (RED_PGA),
    .IR_PGA                (IR_PGA),
    .RED_DC_Comp           (RED_DC_Comp),
    .IR_DC_Comp            (IR_DC_Comp),
    .LED_RED               (LED_RED),
    .LED_IR                (LED_IR),
    .PGA_Gain              (PGA_Gain),
    .DC_Comp               (DC_Comp),
    .RED_ADC_Value         (RED_ADC_Value),
    .IR_ADC_Value          (IR_ADC_Value),
    .red_valid             (red_valid),
    .ir_valid              (ir_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {LED_RED, LED_IR, PGA_Gain, DC_Comp, red_valid, ir_valid} | {16'd0, RED_ADC_Value, IR_ADC_Value};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] win [10];
    int         sum;
    int         exp_prev;
    int         last_strobe;
    int         last_chan;
    int         cyc;

    rst = 1'b1;
    Find_setting_Complete = 1'b0;
    ADC = 8'd0;
    RED_PGA = 4'd3;
    IR_PGA = 4'd5;
    RED_DC_Comp = 8'h20;
    IR_DC_Comp = 8'h40;

    // Reset and idle
    repeat (3) tick();
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outs", all_outs(), 32'd0);
    end

    // Constant ADC over one RED and one IR phase
    ADC = 8'd100;
    Find_setting_Complete = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      check("const_led_red", LED_RED, (c <= 10 || c == 21) ? 1 : 0);
      check("const_led_ir", LED_IR, (c >= 11 && c <= 20) ? 1 : 0);
      check("const_pga", PGA_Gain, (c >= 11 && c <= 20) ? 5 : 3);
      check("const_dc", DC_Comp, (c >= 11 && c <= 20) ? 32'h40 : 32'h20);
      check("const_red_valid", red_valid, (c == 11) ? 1 : 0);
      check("const_ir_valid", ir_valid, (c == 21) ? 1 : 0);
      if (c == 11) check("const_red_val", RED_ADC_Value, 100);
      if (c == 21) check("const_ir_val", IR_ADC_Value, 100);
    end

    // Averaging and truncation: now at timer 0 of a RED phase
    for (int t = 0; t < 10; t++) win[t] = 8'd255;
    win[4] = 8'd10; win[5] = 8'd11; win[6] = 8'd12; win[7] = 8'd14;
    for (int t = 0; t < 10; t++) begin
      ADC = win[t];
      tick();
    end
    check("avg_red_valid", red_valid, 1);
    check("avg_red_val", RED_ADC_Value, 11);
    check("avg_ir_hold", IR_ADC_Value, 100);
    check("avg_led_ir", LED_IR, 1);

    // Enable drop at timer 3 of the IR phase
    ADC = 8'd40;
    repeat (3) tick();
    Find_setting_Complete = 1'b0;
    for (int t = 3; t < 9; t++) begin
      tick();
      check("drop_led_ir", LED_IR, 1);
      check("drop_no_vld", {red_valid, ir_valid}, 0);
    end
    tick();
    check("drop_ir_valid", ir_valid, 1);
    check("drop_ir_val", IR_ADC_Value, 40);
    check("drop_red_hold", RED_ADC_Value, 11);
    check("drop_leds_off", {LED_RED, LED_IR}, 0);
    check("drop_pga_dc", {PGA_Gain, DC_Comp}, 0);
    tick();
    check("drop_idle_vld", {red_valid, ir_valid}, 0);
    check("drop_idle_leds", {LED_RED, LED_IR}, 0);

    // Reset asserted at timer 6 of a RED phase
    Find_setting_Complete = 1'b1;
    ADC = 8'd77;
    tick();
    check("rmid_led_red", LED_RED, 1);
    repeat (6) tick();
    rst = 1'b1;
    Find_setting_Complete = 1'b0;
    tick();
    check("rmid_outs", all_outs(), 0);
    rst = 1'b0;
    tick();
    check("rmid_idle", all_outs(), 0);
    Find_setting_Complete = 1'b1;
    tick();
    check("rmid_fresh_led", {LED_RED, LED_IR}, 2'b10);
    check("rmid_fresh_pga", PGA_Gain, 3);
    repeat (9) tick();
    check("rmid_no_early_vld", red_valid, 0);
    tick();
    check("rmid_red_valid", red_valid, 1);
    check("rmid_red_val", RED_ADC_Value, 77);

    // Long run: 1000 phases with random ADC against a scoreboard
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_prev = 0;
    last_strobe = -1;
    last_chan = -1;
    cyc = 0;
    for (int p = 0; p <= 1000; p++) begin
      sum = 0;
      for (int t = 0; t < 10; t++) begin
        if (p == 1000 && t > 0) break;
        if (t == 0 && p > 0) begin
          check("run_vld", {red_valid, ir_valid}, ((p - 1) % 2 == 0) ? 2'b10 : 2'b01);
          if ((p - 1) % 2 == 0) check("run_red_val", RED_ADC_Value, exp_prev);
          else                  check("run_ir_val", IR_ADC_Value, exp_prev);
        end else begin
          check("run_no_vld", {red_valid, ir_valid}, 0);
        end
        if (red_valid || ir_valid) begin
          if (last_strobe >= 0) check("run_spacing", cyc - last_strobe, 10);
          if (last_chan >= 0) check("run_alternate", red_valid ? 0 : 1, 1 - last_chan);
          last_strobe = cyc;
          last_chan = red_valid ? 0 : 1;
        end
        if (p < 1000) begin
          check("run_leds", {LED_RED, LED_IR}, (p % 2 == 0) ? 2'b10 : 2'b01);
          ADC = 8'($urandom_range(0, 255));
          if (t >= 4 && t <= 7) sum += int'(ADC);
          tick();
          cyc++;
        end
      end
      exp_prev = sum / 4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_adc_sequencer.md
# led_adc_sequencer

- Drives the pulse-oximeter front end: alternates the RED and IR LEDs in fixed-length phases and presents the matching PGA gain and DC-compensation code for each phase.
- Averages ADC samples taken inside a settled window of each phase and emits one 8-bit RED or IR sample per phase, with a one-cycle valid strobe.
- It is the producer side of the FIR filter chain: `IR_ADC_Value`/`ir_valid` feed the IR filter and `RED_ADC_Value`/`red_valid` feed the RED filter, each filter advancing once per valid strobe.

## Interface
Parameters:
- `HALF_PERIOD`, default 10: `CLK` cycles per LED phase.
- `SETTLE`, default 4: cycles after phase start before the first ADC sample is taken.
- `AVG_LOG2`, default 2: log2 of the number of samples averaged per phase. Constraint: `SETTLE + 2**AVG_LOG2 <= HALF_PERIOD - 1`.
- `ADC_W`, default 8: ADC sample width.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `Find_setting_Complete`  in  1  run enable (front-end calibration done)
- `ADC`  in  ADC_W  raw ADC sample, sampled every cycle
- `RED_PGA`, `IR_PGA`  in  4  per-channel PGA gain codes
- `RED_DC_Comp`, `IR_DC_Comp`  in  8  per-channel DC-compensation codes
- `LED_RED`, `LED_IR`  out  1  LED drives; never both high
- `PGA_Gain`  out  4  gain for the active phase
- `DC_Comp`  out  8  DC code for the active phase
- `RED_ADC_Value`, `IR_ADC_Value`  out  ADC_W  averaged samples
- `red_valid`, `ir_valid`  out  1  one-cycle strobes

## Operation
States: IDLE, RED, IR.
- IDLE: LEDs off, phase timer held at 0.
  - If `Find_setting_Complete` = 1, go to RED.
- RED and IR: the phase timer counts 0..HALF_PERIOD-1.
  - At timer = HALF_PERIOD-1, RED goes to IR and IR goes to RED.
  - If the enable is low at that point, go to IDLE instead.
- Enable deassertion mid-phase is ignored until the phase end, so the current phase always completes, including its output and strobe.
- `LED_RED`, `LED_IR`, `PGA_Gain` and `DC_Comp` are registered from the next state. They change in the same cycle the phase begins.
  - PGA and DC codes are captured from `RED_*` or `IR_*` at phase entry and held constant for the whole phase.
- Accumulator (width ADC_W+AVG_LOG2, unsigned):
  - Cleared at phase entry.
  - Adds `ADC` when timer is in [SETTLE, SETTLE+2**AVG_LOG2-1].
- At timer = HALF_PERIOD-1:
  - The channel output register for the current phase is loaded with acc >> AVG_LOG2 (truncating, no rounding).
  - That channel's valid strobe is asserted for exactly the next cycle.
  - The other channel's output register holds its value.
- In IDLE, output registers keep their last values, and PGA_Gain/DC_Comp are 0.

## Timing
- Reset (when `rst` is high at a rising edge): state IDLE, timer 0, accumulator 0. Every output is 0: LEDs, PGA_Gain, DC_Comp, both values, both valids.
- Enable rises in cycle t: LED_RED = 1 from t+1, and timer = 0 in t+1.
- Sample window (defaults): timer 4..7 relative to phase start.
- Valid strobe: asserted in the first cycle of the following phase (or of IDLE), together with the new value.
  - Latency from the last accumulated sample to the strobe: HALF_PERIOD-SETTLE-2**AVG_LOG2+1 cycles.
- Strobe rate:
  - Each channel: one strobe every 2*HALF_PERIOD cycles.
  - red_valid and ir_valid are never high in the same cycle.
- LED switch: break-before-make is not required. LED_RED falls and LED_IR rises on the same edge, and the two are never simultaneously high.
- Reset asserted mid-phase: the partial accumulation is discarded, no strobe is issued, and the block returns to IDLE next cycle.
- Enable still high at a phase end: no idle cycles are inserted between phases.

## Structure
- A shared package `oxi_pkg` holds:
  - the state enum (IDLE/RED/IR);
  - the PGA width (4) and DC_Comp width (8) constants, reused by the FIR and calibration blocks.
- One natural sub-module, `adc_window_avg`, contains:
  - the accumulator, clear, window-enable compare and shift-divide;
  - the parameters SETTLE, AVG_LOG2 and ADC_W.
- The top level holds the FSM, the phase timer and the output registers.

## Test plan
- Reset and idle:
  - Hold `rst` for 3 cycles with the enable low for 20 cycles, then release.
  - Required: all outputs remain 0 and no strobe appears.
- Constant ADC:
  - Apply ADC = 100, RED_PGA = 3, IR_PGA = 5, RED_DC = 0x20, IR_DC = 0x40, then enable.
  - Required: LED_RED high for cycles 1-10 with PGA 3 / DC 0x20, then LED_IR high for cycles 11-20 with PGA 5 / DC 0x40.
  - Required: red_valid at cycle 11 with RED_ADC_Value = 100, and ir_valid at cycle 21 with IR_ADC_Value = 100.
- Averaging and truncation:
  - ADC sequence 10, 11, 12, 14 on timer 4..7 of a RED phase, with 255 outside the window.
  - Required: RED_ADC_Value = 11 (47 >> 2).
- Enable drop mid-phase:
  - Deassert the enable at timer 3 of an IR phase.
  - Required: the phase runs to completion, ir_valid pulses once, the block is in IDLE with both LEDs off, and RED_ADC_Value is unchanged.
- Reset mid-phase:
  - Assert `rst` at timer 6 of a RED phase.
  - Required: no red_valid, all outputs 0 on the next cycle, and a fresh RED phase after re-enable.
- Long run:
  - 1000 phases with random ADC values, checked against a scoreboard model.
  - Required: strobes alternate, spacing is exactly 10 cycles, the LEDs are never both high, and every value matches the model.
